// File: rtl/period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of a slow asynchronous
// signal in clk_in cycles, with a one-cycle valid strobe and loss-of-signal flag.
module period_meter #(
  parameter int unsigned     SIZE    = 26,
  parameter logic [SIZE-1:0] TIMEOUT = SIZE'(60000000)
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            sig_in,
  output logic [SIZE-1:0] period,
  output logic [SIZE-1:0] high_time,
  output logic            valid,
  output logic            timeout,
  output logic            measuring
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            s1;
  logic            s2;
  logic            s3;
  logic            rise;
  logic            fall;
  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] cnt_nxt;
  logic [SIZE-1:0] hcnt;
  logic [SIZE-1:0] hcnt_nxt;
  logic [SIZE-1:0] hlat;
  logic [SIZE-1:0] hlat_nxt;
  logic [SIZE-1:0] period_nxt;
  logic [SIZE-1:0] high_time_nxt;
  logic            valid_nxt;
  logic            timeout_nxt;
  logic            measuring_nxt;

  // Two flops of synchronisation plus one for edge detection; rise and fall see
  // the same latency so the measured intervals carry no offset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Interval counters; both saturate at TIMEOUT so they can never wrap.
  always_comb begin
    cnt_nxt  = cnt;
    hcnt_nxt = hcnt;
    hlat_nxt = hlat;
    if (rise) begin
      cnt_nxt  = ONE;
      hcnt_nxt = ONE;
    end else begin
      if (cnt < TIMEOUT) begin
        cnt_nxt = cnt + ONE;
      end
      if (s2 && (hcnt < TIMEOUT)) begin
        hcnt_nxt = hcnt + ONE;
      end
    end
    if (fall) begin
      hlat_nxt = hcnt;
    end
  end

  // Next state and registered outputs; a rise in the TIMEOUT cycle still reports.
  always_comb begin
    state_nxt     = state;
    period_nxt    = period;
    high_time_nxt = high_time;
    valid_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (rise) begin
          period_nxt    = cnt;
          high_time_nxt = hlat;
          valid_nxt     = 1'b1;
        end else if (cnt == TIMEOUT) begin
          state_nxt = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: begin
        if (rise) begin
          state_nxt = ST_ARMED;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    timeout_nxt   = (state_nxt == ST_TIMEOUT);
    measuring_nxt = (state_nxt == ST_ARMED);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      hlat      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      measuring <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      hlat      <= hlat_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
      measuring <= measuring_nxt;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TIMEOUT=100; valid strobes are captured
// into queues by a monitor and checked against hand-computed values.
module tb_period_meter;

  localparam int unsigned     SIZE = 26;
  localparam logic [SIZE-1:0] TMO  = 26'd100;

  logic            clk_in = 1'b0;
  logic            rst;
  logic            sig_in;
  logic [SIZE-1:0] period;
  logic [SIZE-1:0] high_time;
  logic            valid;
  logic            timeout;
  logic            measuring;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SIZE-1:0] vp[$];
  logic [SIZE-1:0] vh[$];
  int              dbl  = 0;
  int              tcnt = 0;
  logic            prev_v = 1'b0;

  period_meter #(.SIZE(SIZE), .TIMEOUT(TMO)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .measuring (measuring)
  );

  always #5 clk_in = ~clk_in;

  // Record every valid strobe, back-to-back strobes and timeout-high cycles.
  always begin
    @(posedge clk_in);
    #1;
    if (valid) begin
      vp.push_back(period);
      vh.push_back(high_time);
      if (prev_v) dbl++;
    end
    prev_v = valid;
    if (timeout) tcnt++;
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk_in);
      sig_in = v;
    end
  endtask

  task automatic square(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_checks++; if (period !== '0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period); end
    n_checks++; if (high_time !== '0) begin n_fail++; $display("FAIL reset_high: got %0d expected 0", high_time); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    n_checks++; if (measuring !== 1'b0) begin n_fail++; $display("FAIL reset_measuring: got %b expected 0", measuring); end
    rst = 1'b0;
    drive(1'b0, 3);
  endtask

  task automatic test_square;
    int b;
    b = vp.size();
    square(10, 3, 5);
    n_checks++; if (vp.size() - b != 4) begin n_fail++; $display("FAIL sq_count: got %0d expected 4", vp.size() - b); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (vp[b+i] !== SIZE'(10)) begin n_fail++; $display("FAIL sq_period[%0d]: got %0d expected 10", i, vp[b+i]); end
      n_checks++; if (vh[b+i] !== SIZE'(3)) begin n_fail++; $display("FAIL sq_high[%0d]: got %0d expected 3", i, vh[b+i]); end
    end
    n_checks++; if (dbl != 0) begin n_fail++; $display("FAIL sq_single_pulse: got %0d doubles expected 0", dbl); end
    n_checks++; if (measuring !== 1'b1) begin n_fail++; $display("FAIL sq_measuring: got %b expected 1", measuring); end
  endtask

  task automatic test_change;
    int b;
    b = vp.size();
    square(20, 15, 3);
    n_checks++; if (vp.size() - b != 3) begin n_fail++; $display("FAIL chg_count: got %0d expected 3", vp.size() - b); end
    n_checks++; if (vp[b] !== SIZE'(10)) begin n_fail++; $display("FAIL chg_mixed_period: got %0d expected 10", vp[b]); end
    n_checks++; if (vh[b] !== SIZE'(3)) begin n_fail++; $display("FAIL chg_mixed_high: got %0d expected 3", vh[b]); end
    for (int i = 1; i < 3; i++) begin
      n_checks++; if (vp[b+i] !== SIZE'(20)) begin n_fail++; $display("FAIL chg_period[%0d]: got %0d expected 20", i, vp[b+i]); end
      n_checks++; if (vh[b+i] !== SIZE'(15)) begin n_fail++; $display("FAIL chg_high[%0d]: got %0d expected 15", i, vh[b+i]); end
    end
  endtask

  task automatic test_timeout;
    int b;
    b = vp.size();
    @(negedge clk_in);
    sig_in = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      @(negedge clk_in);
      if (i == 102) begin
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", timeout); end
        n_checks++; if (measuring !== 1'b1) begin n_fail++; $display("FAIL to_meas_before: got %b expected 1", measuring); end
      end
      if (i == 103) begin
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_assert: got %b expected 1", timeout); end
        n_checks++; if (measuring !== 1'b0) begin n_fail++; $display("FAIL to_meas_after: got %b expected 0", measuring); end
        n_checks++; if (period !== SIZE'(20)) begin n_fail++; $display("FAIL to_period_hold: got %0d expected 20", period); end
        n_checks++; if (high_time !== SIZE'(15)) begin n_fail++; $display("FAIL to_high_hold: got %0d expected 15", high_time); end
      end
      if (i == 160) begin
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_level: got %b expected 1", timeout); end
      end
      sig_in = (i < 5);
    end
    n_checks++; if (vp.size() - b != 1) begin n_fail++; $display("FAIL to_count: got %0d expected 1", vp.size() - b); end
  endtask

  task automatic test_restart;
    int b;
    b = vp.size();
    for (int j = 0; j < 20; j++) begin
      @(negedge clk_in);
      if (j == 2) begin
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL rs_still_to: got %b expected 1", timeout); end
      end
      if (j == 3) begin
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rs_clear: got %b expected 0", timeout); end
        n_checks++; if (measuring !== 1'b1) begin n_fail++; $display("FAIL rs_meas: got %b expected 1", measuring); end
        n_checks++; if (vp.size() != b) begin n_fail++; $display("FAIL rs_no_valid: got %0d strobes expected 0", vp.size() - b); end
      end
      sig_in = ((j % 10) < 3);
    end
    n_checks++; if (vp.size() - b != 1) begin n_fail++; $display("FAIL rs_count: got %0d expected 1", vp.size() - b); end
    n_checks++; if (vp[b] !== SIZE'(10)) begin n_fail++; $display("FAIL rs_period: got %0d expected 10", vp[b]); end
    n_checks++; if (vh[b] !== SIZE'(3)) begin n_fail++; $display("FAIL rs_high: got %0d expected 3", vh[b]); end
  endtask

  task automatic test_boundary;
    int b;
    int t0;
    drive(1'b0, 120);
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL bd_pre_to: got %b expected 1", timeout); end
    square(100, 40, 1);
    t0 = tcnt;
    b = vp.size();
    square(100, 40, 2);
    n_checks++; if (tcnt != t0) begin n_fail++; $display("FAIL bd_no_timeout: got %0d timeout cycles expected 0", tcnt - t0); end
    n_checks++; if (vp.size() - b != 2) begin n_fail++; $display("FAIL bd_count: got %0d expected 2", vp.size() - b); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (vp[b+i] !== SIZE'(100)) begin n_fail++; $display("FAIL bd_period[%0d]: got %0d expected 100", i, vp[b+i]); end
      n_checks++; if (vh[b+i] !== SIZE'(40)) begin n_fail++; $display("FAIL bd_high[%0d]: got %0d expected 40", i, vh[b+i]); end
    end
  endtask

  task automatic test_reset_mid;
    int b;
    square(10, 3, 2);
    drive(1'b1, 2);
    @(negedge clk_in);
    rst = 1'b1;
    sig_in = 1'b0;
    @(negedge clk_in);
    n_checks++; if (period !== '0) begin n_fail++; $display("FAIL rm_period: got %0d expected 0", period); end
    n_checks++; if (high_time !== '0) begin n_fail++; $display("FAIL rm_high: got %0d expected 0", high_time); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", valid); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rm_timeout: got %b expected 0", timeout); end
    n_checks++; if (measuring !== 1'b0) begin n_fail++; $display("FAIL rm_measuring: got %b expected 0", measuring); end
    rst = 1'b0;
    drive(1'b0, 3);
    b = vp.size();
    square(10, 3, 3);
    n_checks++; if (vp.size() - b != 2) begin n_fail++; $display("FAIL rm_count: got %0d expected 2", vp.size() - b); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (vp[b+i] !== SIZE'(10)) begin n_fail++; $display("FAIL rm_period2[%0d]: got %0d expected 10", i, vp[b+i]); end
      n_checks++; if (vh[b+i] !== SIZE'(3)) begin n_fail++; $display("FAIL rm_high2[%0d]: got %0d expected 3", i, vh[b+i]); end
    end
  endtask

  task automatic test_min_period;
    int b;
    b = vp.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      sig_in = ((i % 2) == 0);
    end
    drive(1'b0, 5);
    n_checks++; if (vp.size() - b != 10) begin n_fail++; $display("FAIL mp_count: got %0d expected 10", vp.size() - b); end
    n_checks++; if (vp[b] !== SIZE'(10)) begin n_fail++; $display("FAIL mp_first_period: got %0d expected 10", vp[b]); end
    for (int i = 1; i < 10; i++) begin
      n_checks++; if (vp[b+i] !== SIZE'(2)) begin n_fail++; $display("FAIL mp_period[%0d]: got %0d expected 2", i, vp[b+i]); end
      n_checks++; if (vh[b+i] !== SIZE'(1)) begin n_fail++; $display("FAIL mp_high[%0d]: got %0d expected 1", i, vh[b+i]); end
    end
    n_checks++; if (dbl != 0) begin n_fail++; $display("FAIL mp_single_pulse: got %0d doubles expected 0", dbl); end
  endtask

  initial begin
    rst = 1'b1;
    sig_in = 1'b0;
    test_reset;
    test_square;
    test_change;
    test_timeout;
    test_restart;
    test_boundary;
    test_reset_mid;
    test_min_period;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
